// File: rtl/persp_div_simple_pkg.sv
// Shared sizing and saturation helpers for the perspective-divide unit.
// Everything is derived from intBits/decimalBits so the divider can be re-sized.
package persp_div_simple_pkg;

  localparam int INT_BITS_DEF = 3;
  localparam int DEC_BITS_DEF = 3;

  function automatic int calcW(input int intBits, input int decimalBits);
    return intBits + decimalBits + 1;
  endfunction

  // One quotient bit per dividend bit: |num| pre-scaled by 2^decimalBits.
  function automatic int calcQ(input int intBits, input int decimalBits);
    return calcW(intBits, decimalBits) + decimalBits;
  endfunction

  function automatic logic [31:0] maxPos(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Bit pattern of the most negative value, which is also its magnitude.
  function automatic logic [31:0] minNeg(input int w);
    return 32'd1 << (w - 1);
  endfunction

  localparam int W = calcW(INT_BITS_DEF, DEC_BITS_DEF);
  localparam int Q = calcQ(INT_BITS_DEF, DEC_BITS_DEF);
  localparam logic [W-1:0] MAX_POS = W'(maxPos(W));
  localparam logic [W-1:0] MIN_NEG = W'(minNeg(W));

endpackage

// File: rtl/persp_div_simple_if.sv
// Vertex-in / projected-pair-out bus of the perspective-divide unit.
interface persp_div_simple_if
  import persp_div_simple_pkg::*;
#(
  parameter int PW = W
);
  logic          valid_in;
  logic [PW-1:0] x;
  logic [PW-1:0] y;
  logic [PW-1:0] z;
  logic          valid_out;
  logic [PW-1:0] newX;
  logic [PW-1:0] newY;

  modport master (output valid_in, x, y, z, input valid_out, newX, newY);
  modport slave  (input valid_in, x, y, z, output valid_out, newX, newY);
endinterface

// File: rtl/persp_div_simple_fixed_div_pipe.sv
// Signed pipelined fixed-point divider: quot = sat(trunc(num*2^decimalBits/den)).
// Restoring division, one quotient bit per stage, with its own valid bit.
module fixed_div_pipe
  import persp_div_simple_pkg::*;
#(
  parameter int intBits     = INT_BITS_DEF,
  parameter int decimalBits = DEC_BITS_DEF,
  localparam int DW = calcW(intBits, decimalBits),
  localparam int DQ = calcQ(intBits, decimalBits)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          validIn,
  input  logic [DW-1:0] num,
  input  logic [DW-1:0] den,
  output logic          validOut,
  output logic [DW-1:0] quot
);
  localparam logic [DW-1:0] SAT_POS = DW'(maxPos(DW));
  localparam logic [DW-1:0] SAT_NEG = DW'(minNeg(DW));
  localparam logic [DQ-1:0] POS_LIM = DQ'(maxPos(DW));
  localparam logic [DQ-1:0] NEG_LIM = DQ'(minNeg(DW));

  function automatic logic [DW-1:0] absVal(input logic [DW-1:0] v);
    return v[DW-1] ? (~v + 1'b1) : v;
  endfunction

  // Input capture register isolates the divider from the upstream transform stage.
  logic          inVld;
  logic [DW-1:0] inNum, inDen;

  logic [DQ:0]   vld, neg, numZero, denZero;
  logic [DW-1:0] rem  [0:DQ-1];
  logic [DQ-1:0] dvd  [0:DQ-1];
  logic [DW-1:0] dvsr [0:DQ-1];
  logic [DQ-1:0] quo  [0:DQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      inVld  <= 1'b0;
      vld[0] <= 1'b0;
    end else begin
      inVld  <= validIn;
      vld[0] <= inVld;
    end
    inNum      <= num;
    inDen      <= den;
    neg[0]     <= inNum[DW-1] ^ inDen[DW-1];
    numZero[0] <= (inNum == '0);
    denZero[0] <= (inDen == '0);
    rem[0]     <= '0;
    dvd[0]     <= {absVal(inNum), {decimalBits{1'b0}}};
    dvsr[0]    <= absVal(inDen);
    quo[0]     <= '0;
  end

  for (genvar s = 1; s <= DQ; s++) begin : gStep
    logic [DW:0]   trial;
    logic          ge;
    logic [DW-1:0] remNext;

    assign trial   = {rem[s-1], dvd[s-1][DQ-1]};
    assign ge      = trial >= {1'b0, dvsr[s-1]};
    // Remainder stays below the divisor, so W-bit modular subtraction is exact.
    assign remNext = ge ? (trial[DW-1:0] - dvsr[s-1]) : trial[DW-1:0];

    always_ff @(posedge clk) begin
      if (rst) vld[s] <= 1'b0;
      else     vld[s] <= vld[s-1];
      neg[s]     <= neg[s-1];
      numZero[s] <= numZero[s-1];
      denZero[s] <= denZero[s-1];
      quo[s]     <= {quo[s-1][DQ-2:0], ge};
    end

    if (s < DQ) begin : gCarry
      always_ff @(posedge clk) begin
        rem[s]  <= remNext;
        dvd[s]  <= dvd[s-1] << 1;
        dvsr[s] <= dvsr[s-1];
      end
    end
  end

  logic [DW-1:0] result;

  always_comb begin
    result = '0;
    if (denZero[DQ]) begin
      if (!numZero[DQ]) result = neg[DQ] ? SAT_NEG : SAT_POS;
    end else if (neg[DQ]) begin
      result = (quo[DQ] > NEG_LIM) ? SAT_NEG : (~quo[DQ][DW-1:0] + 1'b1);
    end else begin
      result = (quo[DQ] > POS_LIM) ? SAT_POS : quo[DQ][DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      validOut <= 1'b0;
      quot     <= '0;
    end else begin
      validOut <= vld[DQ];
      if (vld[DQ]) quot <= result;
    end
  end

endmodule

// File: rtl/persp_div_simple.sv
// Perspective divide: newX = x/z, newY = y/z in signed fixed point.
// Two identical divider pipes share z; valid travels with the X pipe.
module persp_div_simple
  import persp_div_simple_pkg::*;
#(
  parameter int intBits     = INT_BITS_DEF,
  parameter int decimalBits = DEC_BITS_DEF
) (
  input logic               clk,
  input logic               rst,
  persp_div_simple_if.slave bus
);
  logic unusedValidY;

  fixed_div_pipe #(.intBits(intBits), .decimalBits(decimalBits)) uDivX (
    .clk      (clk),
    .rst      (rst),
    .validIn  (bus.valid_in),
    .num      (bus.x),
    .den      (bus.z),
    .validOut (bus.valid_out),
    .quot     (bus.newX)
  );

  fixed_div_pipe #(.intBits(intBits), .decimalBits(decimalBits)) uDivY (
    .clk      (clk),
    .rst      (rst),
    .validIn  (bus.valid_in),
    .num      (bus.y),
    .den      (bus.z),
    .validOut (unusedValidY),
    .quot     (bus.newY)
  );

endmodule

// File: tb/tb_persp_div_simple.sv
// Self-checking bench for persp_div_simple at default sizing (W=7, scale 8, latency 12).
module tb_persp_div_simple;
  localparam int LAT = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  persp_div_simple_if #(.PW(7)) bus ();

  persp_div_simple #(.intBits(3), .decimalBits(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit         v;
    logic [6:0] ex;
    logic [6:0] ey;
  } exp_t;

  exp_t expQ[$];

  // Reference: exact integer quotient, truncated toward zero, then clamped.
  function automatic logic [6:0] refDiv(input logic [6:0] n, input logic [6:0] d);
    int ni, di, q;
    ni = int'($signed(n));
    di = int'($signed(d));
    if (di == 0) q = (ni > 0) ? 63 : ((ni < 0) ? -64 : 0);
    else         q = (ni * 8) / di;
    if (q > 63)  q = 63;
    if (q < -64) q = -64;
    return 7'(q);
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exv);
    checks++;
    assert (obs === exv) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exv);
    end
  endtask

  task automatic primeQueue();
    exp_t e;
    e.v = 1'b0; e.ex = '0; e.ey = '0;
    expQ.delete();
    for (int i = 0; i < LAT; i++) expQ.push_back(e);
  endtask

  task automatic step(input bit v, input logic [6:0] xi, input logic [6:0] yi, input logic [6:0] zi);
    exp_t e;
    bus.valid_in = v;
    bus.x = xi;
    bus.y = yi;
    bus.z = zi;
    @(posedge clk);
    #1;
    e.v  = v;
    e.ex = refDiv(xi, zi);
    e.ey = refDiv(yi, zi);
    expQ.push_back(e);
    e = expQ.pop_front();
    chk("valid_out", {6'd0, bus.valid_out}, {6'd0, e.v});
    if (e.v) begin
      chk("newX", bus.newX, e.ex);
      chk("newY", bus.newY, e.ey);
    end
  endtask

  task automatic resetPulse();
    rst = 1'b1;
    bus.valid_in = 1'b1;
    bus.x = 7'($urandom);
    bus.y = 7'($urandom);
    bus.z = 7'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid_out", {6'd0, bus.valid_out}, 7'd0);
    chk("rst_newX", bus.newX, 7'd0);
    chk("rst_newY", bus.newY, 7'd0);
    primeQueue();
  endtask

  initial begin
    logic [20:0] cnt;
    bus.valid_in = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.z = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid_out", {6'd0, bus.valid_out}, 7'd0);
    chk("init_newX", bus.newX, 7'd0);
    chk("init_newY", bus.newY, 7'd0);
    rst = 1'b0;
    primeQueue();

    // Directed cases: basic, signs/truncation, saturation, divide by zero.
    step(1'b1, 7'd16,  7'd8,   7'd8);
    step(1'b1, 7'd16,  7'd8,   7'd16);
    step(1'b1, 7'h70,  7'd1,   7'd8);
    step(1'b1, 7'd1,   7'h7F,  7'd24);
    step(1'b1, 7'h7F,  7'd1,   7'd24);
    step(1'b1, 7'h78,  7'h78,  7'h78);
    step(1'b1, 7'd56,  7'h40,  7'd4);
    step(1'b1, 7'h40,  7'h40,  7'h78);
    step(1'b1, 7'd5,   7'h7B,  7'd0);
    step(1'b1, 7'd0,   7'd0,   7'd0);
    step(1'b0, 7'd3,   7'd3,   7'd3);
    step(1'b1, 7'h40,  7'h3F,  7'h40);
    step(1'b1, 7'h3F,  7'h41,  7'd1);
    for (int i = 0; i < LAT; i++) step(1'b0, '0, '0, '0);

    // Random stream with bubbles, frequent z=0, and a mid-stream reset.
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] zr;
      zr = ($urandom_range(0, 15) == 0) ? 7'd0 : 7'($urandom);
      if (i == 1500) resetPulse();
      else step($urandom_range(0, 3) != 0, 7'($urandom), 7'($urandom), zr);
    end

    // Back-to-back counting sweep (x fastest, then y, then z), two windows.
    cnt = '0;
    for (int i = 0; i < 20000; i++) begin
      step(1'b1, cnt[6:0], cnt[13:7], cnt[20:14]);
      cnt = cnt + 21'd1;
    end
    cnt = {7'h3F, 14'h3F00};
    for (int i = 0; i < 20000; i++) begin
      step(1'b1, cnt[6:0], cnt[13:7], cnt[20:14]);
      cnt = cnt + 21'd1;
    end
    for (int i = 0; i < LAT + 2; i++) step(1'b0, '0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
